regfile_port_initiator: RTL and testbench

REGFILE_PORT_INITIATOR -- requirements
Module: regfile_port_initiator

---
 rtl/regfile_port_initiator.sv | 127 ++++++++++++
 tb/tb_regfile_port_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_initiator.sv
// Register-file port initiator: turns a command stream into RF write and read-port cycles.
// Reads are tracked by latency and their data returns in order through a small FIFO.
module regfile_port_initiator #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [DATA_W-1:0]   cmd_value,
    input  logic [DATA_W/8-1:0] cmd_byteMask,
    output logic [ADDR_W-1:0]   rf_read_address,
    output logic                rf_write,
    output logic [ADDR_W-1:0]   rf_write_address,
    output logic [DATA_W-1:0]   rf_write_value,
    output logic [DATA_W/8-1:0] rf_write_byteMask,
    input  logic [DATA_W-1:0]   rf_read_value,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_value,
    output logic                busy
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + READ_LATENCY + 2) + 1;

    logic                    readIssue;
    logic [READ_LATENCY-1:0] readPipe;
    logic [READ_LATENCY:0]   histValid;
    logic [ADDR_W-1:0]       histAddress [READ_LATENCY+1];
    logic [PTR_W:0]          writePtr;
    logic [PTR_W:0]          readPtr;
    logic [PTR_W:0]          occupancy;
    logic [DATA_W-1:0]       fifoMem [RESP_DEPTH];
    logic [CNT_W-1:0]        inFlight;
    logic [CNT_W-1:0]        pending;
    logic                    creditFull;
    logic                    rawHazard;
    logic                    writeAccept;
    logic                    readAccept;
    logic                    push;
    logic                    pop;

    always_comb begin
        inFlight = CNT_W'(readIssue);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inFlight = inFlight + CNT_W'(readPipe[i]);
        end
    end

    assign occupancy  = writePtr - readPtr;
    assign pending    = inFlight + CNT_W'(occupancy);
    assign creditFull = pending >= CNT_W'(RESP_DEPTH);

    // A read must not overtake a write to the same register still in its window.
    always_comb begin
        rawHazard = 1'b0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            if (histValid[i] && histAddress[i] == cmd_address) begin
                rawHazard = 1'b1;
            end
        end
    end

    assign cmd_ready   = reset && (cmd_write || (!creditFull && !rawHazard));
    assign writeAccept = cmd_valid && cmd_ready && cmd_write;
    assign readAccept  = cmd_valid && cmd_ready && !cmd_write;

    assign push      = readPipe[READ_LATENCY-1];
    assign rsp_valid = writePtr != readPtr;
    assign rsp_value = fifoMem[readPtr[PTR_W-1:0]];
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = readIssue || (|readPipe) || rsp_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rf_write          <= 1'b0;
            rf_write_address  <= '0;
            rf_write_value    <= '0;
            rf_write_byteMask <= '0;
            rf_read_address   <= '0;
            readIssue         <= 1'b0;
            readPipe          <= '0;
            histValid         <= '0;
            writePtr          <= '0;
            readPtr           <= '0;
        end else begin
            rf_write <= writeAccept;
            if (writeAccept) begin
                rf_write_address  <= cmd_address;
                rf_write_value    <= cmd_value;
                rf_write_byteMask <= cmd_byteMask;
            end
            if (readAccept) begin
                rf_read_address <= cmd_address;
            end
            readIssue <= readAccept;
            readPipe  <= (readPipe << 1) | READ_LATENCY'(readIssue);
            histValid <= {histValid[READ_LATENCY-1:0], writeAccept};
            if (push) begin
                writePtr <= writePtr + (PTR_W+1)'(1);
            end
            if (pop) begin
                readPtr <= readPtr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        histAddress[0] <= cmd_address;
        for (int i = 1; i <= READ_LATENCY; i++) begin
            histAddress[i] <= histAddress[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[writePtr[PTR_W-1:0]] <= rf_read_value;
        end
    end

endmodule

// File: tb/tb_regfile_port_initiator.sv
// Randomized bench for regfile_port_initiator with a register-file stub
// and a cycle-level scoreboard of commands, hazards and responses.
module tb_regfile_port_initiator;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 64;
    localparam int RL     = 2;
    localparam int DEPTH  = 4;
    localparam int MW     = DATA_W / 8;

    typedef struct packed {
        int         due;
        logic [6:0] addr;
    } rdT;

    typedef struct packed {
        int         cyc;
        logic [6:0] addr;
    } wrT;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_value;
    logic [MW-1:0]     cmd_byteMask;
    logic [ADDR_W-1:0] rf_read_address;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_write_address;
    logic [DATA_W-1:0] rf_write_value;
    logic [MW-1:0]     rf_write_byteMask;
    logic [DATA_W-1:0] rf_read_value;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_value;
    logic              busy;

    always #5 clock = ~clock;

    regfile_port_initiator #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .READ_LATENCY(RL),
        .RESP_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_address(cmd_address),
        .cmd_value(cmd_value),
        .cmd_byteMask(cmd_byteMask),
        .rf_read_address(rf_read_address),
        .rf_write(rf_write),
        .rf_write_address(rf_write_address),
        .rf_write_value(rf_write_value),
        .rf_write_byteMask(rf_write_byteMask),
        .rf_read_value(rf_read_value),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_value(rsp_value),
        .busy(busy)
    );

    function automatic logic [63:0] seedVal(input int i);
        return {32'(i) * 32'h9E3779B1, 32'hC0DE0000 | 32'(i)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] nw,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < MW; b++) begin
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Register-file stub: write lands at the clock edge, read data is
    // the array contents addressed RL cycles earlier.
    logic [63:0] rfMem [128];
    logic [6:0]  addrPipe [RL];

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) rfMem[i] <= seedVal(i);
        end else if (rf_write) begin
            for (int b = 0; b < MW; b++) begin
                if (rf_write_byteMask[b]) begin
                    rfMem[rf_write_address][8*b +: 8] <= rf_write_value[8*b +: 8];
                end
            end
        end
        addrPipe[0] <= rf_read_address;
        for (int k = 1; k < RL; k++) addrPipe[k] <= addrPipe[k-1];
    end

    assign rf_read_value = rfMem[addrPipe[RL-1]];

    rdT          pendRd [$];
    wrT          wrHist [$];
    logic [63:0] fifoQ [$];
    logic [63:0] refMem [128];
    bit          pendWrValid;
    logic [6:0]  pendWrAddr;
    logic [63:0] pendWrVal;
    logic [7:0]  pendWrMask;
    bit          expWrite;
    logic [6:0]  expWAddr;
    logic [63:0] expWVal;
    logic [7:0]  expWMask;
    logic [6:0]  expRdAddr;
    int          cyc;
    int          checks;
    int          errors;

    task automatic checkEq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit hazard(input logic [6:0] a);
        foreach (wrHist[i]) begin
            if (wrHist[i].addr == a && cyc - wrHist[i].cyc >= 1 &&
                cyc - wrHist[i].cyc <= RL + 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input bit rst, input bit v, input bit w,
                        input logic [6:0] a, input logic [63:0] d,
                        input logic [7:0] m, input bit rr,
                        output bit acc, output bit rdy);
        bit modelReady;
        rdT r;
        wrT h;
        @(negedge clock);
        reset        = rst;
        cmd_valid    = v;
        cmd_write    = w;
        cmd_address  = a;
        cmd_value    = d;
        cmd_byteMask = m;
        rsp_ready    = rr;
        #1;
        modelReady = rst && (w || (!hazard(a) &&
                     (pendRd.size() + fifoQ.size() < DEPTH)));
        checkEq("cmd_ready", 64'(cmd_ready), 64'(modelReady));
        checkEq("rf_write", 64'(rf_write), 64'(expWrite));
        checkEq("rf_write_address", 64'(rf_write_address), 64'(expWAddr));
        checkEq("rf_write_value", rf_write_value, expWVal);
        checkEq("rf_write_byteMask", 64'(rf_write_byteMask), 64'(expWMask));
        checkEq("rf_read_address", 64'(rf_read_address), 64'(expRdAddr));
        checkEq("rsp_valid", 64'(rsp_valid), 64'(fifoQ.size() != 0));
        if (fifoQ.size() != 0) checkEq("rsp_value", rsp_value, fifoQ[0]);
        checkEq("busy", 64'(busy), 64'(pendRd.size() != 0 || fifoQ.size() != 0));
        rdy = cmd_ready;
        acc = v && modelReady;
        if (!rst) begin
            pendRd.delete();
            fifoQ.delete();
            wrHist.delete();
            pendWrValid = 1'b0;
            expWrite = 1'b0;
            expWAddr = '0;
            expWVal = '0;
            expWMask = '0;
            expRdAddr = '0;
            for (int i = 0; i < 128; i++) refMem[i] = seedVal(i);
        end else begin
            if (rr && fifoQ.size() != 0) void'(fifoQ.pop_front());
            while (pendRd.size() != 0 && pendRd[0].due == cyc) begin
                fifoQ.push_back(refMem[pendRd[0].addr]);
                void'(pendRd.pop_front());
            end
            if (pendWrValid) begin
                refMem[pendWrAddr] = merge(refMem[pendWrAddr], pendWrVal, pendWrMask);
            end
            pendWrValid = acc && w;
            expWrite = acc && w;
            if (acc && w) begin
                expWAddr = a;
                expWVal = d;
                expWMask = m;
                pendWrAddr = a;
                pendWrVal = d;
                pendWrMask = m;
                h.cyc = cyc;
                h.addr = a;
                wrHist.push_back(h);
            end
            if (acc && !w) begin
                expRdAddr = a;
                r.due = cyc + RL + 1;
                r.addr = a;
                pendRd.push_back(r);
            end
            while (wrHist.size() != 0 && cyc - wrHist[0].cyc > RL + 1) begin
                void'(wrHist.pop_front());
            end
        end
        cyc++;
    endtask

    task automatic idle(input bit rr, input int n);
        bit acc;
        bit rdy;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0, rr, acc, rdy);
    endtask

    initial begin
        bit acc;
        bit rdy;
        bit done;
        int k;
        int readyCnt;
        int blocked;
        checks = 0;
        errors = 0;
        cyc = 0;
        pendWrValid = 1'b0;
        expWrite = 1'b0;
        expWAddr = '0;
        expWVal = '0;
        expWMask = '0;
        expRdAddr = '0;
        for (int i = 0; i < 128; i++) refMem[i] = seedVal(i);
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_address = '0;
        cmd_value = '0;
        cmd_byteMask = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);

        // single write
        step(1, 1, 1, 7'd5, 64'h1122334455667788, 8'hFF, 0, acc, rdy);
        idle(0, 2);

        // read returning 0xDEAD three edges after accept
        step(1, 1, 1, 7'd9, 64'hDEAD, 8'hFF, 0, acc, rdy);
        idle(0, 3);
        step(1, 1, 0, 7'd9, 64'd0, 8'd0, 0, acc, rdy);
        checkEq("readAccepted", 64'(rdy), 64'd1);
        idle(0, 4);
        checkEq("rspDeadValid", 64'(rsp_valid), 64'd1);
        checkEq("rspDeadValue", rsp_value, 64'hDEAD);
        idle(1, 4);

        // credit limit with a stalled consumer
        k = 0;
        readyCnt = 0;
        for (int t = 0; t < 6; t++) begin
            step(1, 1, 0, 7'(20 + k), 64'd0, 8'd0, 0, acc, rdy);
            readyCnt += int'(rdy);
            if (acc) k++;
        end
        checkEq("creditAccepted", 64'(readyCnt), 64'd4);
        for (int t = 0; t < 40 && k < 6; t++) begin
            step(1, 1, 0, 7'(20 + k), 64'd0, 8'd0, 1, acc, rdy);
            if (acc) k++;
        end
        checkEq("creditDrainAll", 64'(k), 64'd6);
        idle(1, 8);

        // read-after-write hold
        step(1, 1, 1, 7'd3, 64'hA5A5_0303_5A5A_3030, 8'h0F, 1, acc, rdy);
        blocked = 0;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            step(1, 1, 0, 7'd3, 64'd0, 8'd0, 1, acc, rdy);
            if (acc) done = 1'b1;
            else blocked += int'(!rdy);
        end
        checkEq("rawHoldCycles", 64'(blocked), 64'(RL + 1));
        checkEq("rawReleased", 64'(done), 64'd1);
        idle(1, 5);
        step(1, 1, 1, 7'd3, 64'h0, 8'hF0, 1, acc, rdy);
        step(1, 1, 0, 7'd4, 64'd0, 8'd0, 1, acc, rdy);
        checkEq("rawOtherAddr", 64'(rdy), 64'd1);
        idle(1, 6);

        // full FIFO then streaming reads with the consumer ready
        for (int t = 0; t < 4; t++) step(1, 1, 0, 7'(40 + t), 64'd0, 8'd0, 0, acc, rdy);
        idle(0, 4);
        checkEq("fullValid", 64'(rsp_valid), 64'd1);
        k = 0;
        for (int t = 0; t < 16; t++) begin
            step(1, 1, 0, 7'(44 + k), 64'd0, 8'd0, 1, acc, rdy);
            if (acc) k++;
        end
        idle(1, 8);

        // reset with reads in flight
        step(1, 1, 0, 7'd50, 64'd0, 8'd0, 1, acc, rdy);
        step(1, 1, 0, 7'd51, 64'd0, 8'd0, 1, acc, rdy);
        step(0, 0, 0, 7'd0, 64'd0, 8'd0, 1, acc, rdy);
        idle(1, 1);
        checkEq("rstRspValid", 64'(rsp_valid), 64'd0);
        checkEq("rstBusy", 64'(busy), 64'd0);
        idle(1, 6);

        // random traffic
        for (int t = 0; t < 4000; t++) begin
            bit rst;
            bit v;
            bit w;
            bit rr;
            logic [6:0] a;
            rst = $urandom_range(0, 199) != 0;
            v = $urandom_range(0, 9) < 7;
            w = $urandom_range(0, 9) < 4;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                            : 7'($urandom_range(0, 7));
            rr = $urandom_range(0, 9) < 6;
            step(rst, v, w, a, {$urandom, $urandom}, 8'($urandom), rr, acc, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
